// File: rtl/serial_add_pkg.sv
// Shared types and constants for the nibble-serial add/subtract sequencer.
package serial_add_pkg;

  // The sequencer time-shares one FourBitAdder, so the slice width is fixed.
  localparam int NIBBLE_W        = 4;

  // Operand width in nibbles when the instantiating level does not override it.
  localparam int NIBBLES_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_add_sequencer_if.sv
// Operand/control and result bundle between the requesting logic and the
// sequencer. The master drives operands and start; the slave is the sequencer.
interface serial_add_sequencer_if
  import serial_add_pkg::*;
#(
  parameter int NIBBLES = NIBBLES_DEFAULT
) ();

  localparam int W = NIBBLE_W * NIBBLES;

  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         overflow;

  modport master (
    output start, sub, a, b,
    input  ready, busy, done, result, cout, overflow
  );

  modport slave (
    input  start, sub, a, b,
    output ready, busy, done, result, cout, overflow
  );

endinterface

// File: rtl/FourBitAdder.sv
// 4-bit ripple-carry adder: the only arithmetic element of the sequencer.
module FourBitAdder (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Ci,
  output logic       Cout,
  output logic [3:0] Sum
);

  logic [4:0] c;

  assign c[0] = Ci;

  // One full-adder cell per bit, carry rippling upward.
  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign Sum[i]  = A[i] ^ B[i] ^ c[i];
    assign c[i+1]  = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
  end

  assign Cout = c[4];

endmodule

// File: rtl/serial_add_sequencer.sv
// Adds or subtracts two W-bit operands one nibble per clock through a single
// FourBitAdder, least-significant nibble first, carry held in a register.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | ready=1, waiting for start; result/cout/overflow hold
// RUN   | one nibble per cycle through the adder, NIBBLES cycles total
// DONE  | done=1 for one cycle, result/cout/overflow valid
module serial_add_sequencer
  import serial_add_pkg::*;
#(
  parameter int NIBBLES = NIBBLES_DEFAULT
) (
  input logic                   clk,
  input logic                   reset,
  serial_add_sequencer_if.slave bus
);

  localparam int            W        = NIBBLE_W * NIBBLES;
  localparam int            IW       = $clog2(NIBBLES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  state_t                state;
  logic [W-1:0]          op_a;
  logic [W-1:0]          op_b;
  logic                  carry;
  logic [IW-1:0]         idx;
  logic                  msb_a;
  logic                  msb_b;

  logic                  ready_q;
  logic                  busy_q;
  logic                  done_q;
  logic [W-1:0]          result_q;
  logic                  cout_q;
  logic                  ovf_q;

  logic [NIBBLE_W-1:0]   nib_sum;
  logic                  nib_cout;

  FourBitAdder u_adder (
    .A    (op_a[NIBBLE_W-1:0]),
    .B    (op_b[NIBBLE_W-1:0]),
    .Ci   (carry),
    .Cout (nib_cout),
    .Sum  (nib_sum)
  );

  // Sequencer FSM: operand latch, nibble shifting, carry and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      op_a     <= '0;
      op_b     <= '0;
      carry    <= 1'b0;
      idx      <= '0;
      msb_a    <= 1'b0;
      msb_b    <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            // Subtraction is A + ~B + 1: invert B here and seed the carry.
            op_a    <= bus.a;
            op_b    <= bus.sub ? ~bus.b : bus.b;
            carry   <= bus.sub;
            idx     <= '0;
            // Sign bits kept aside because op_a/op_b are consumed by shifting.
            msb_a   <= bus.a[W-1];
            msb_b   <= bus.sub ? ~bus.b[W-1] : bus.b[W-1];
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state   <= RUN;
          end
        end

        RUN: begin
          result_q <= {nib_sum, result_q[W-1:NIBBLE_W]};
          carry    <= nib_cout;
          op_a     <= {{NIBBLE_W{1'b0}}, op_a[W-1:NIBBLE_W]};
          op_b     <= {{NIBBLE_W{1'b0}}, op_b[W-1:NIBBLE_W]};
          idx      <= idx + IW'(1);
          if (idx == LAST_IDX) begin
            // nib_sum[3] is the final result MSB on the last nibble.
            cout_q <= nib_cout;
            ovf_q  <= (msb_a == msb_b) && (nib_sum[NIBBLE_W-1] != msb_a);
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end
        end

        DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state   <= IDLE;
        end

        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready    = ready_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Self-checking bench for serial_add_sequencer (NIBBLES=4, W=16).
module tb_serial_add_sequencer;
  import serial_add_pkg::*;

  localparam int N = 4;
  localparam int W = NIBBLE_W * N;

  typedef struct {
    logic [W-1:0] res;
    logic         co;
    logic         ov;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  exp_t sbq[$];

  always #5 clk = ~clk;

  serial_add_sequencer_if #(.NIBBLES(N)) bus ();

  serial_add_sequencer #(.NIBBLES(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference: plain wide arithmetic, signed range check for overflow.
  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv);
    exp_t         e;
    logic [W:0]   t;
    longint       sa, sb, sr, lim;
    sa  = longint'($signed(av));
    sb  = longint'($signed(bv));
    lim = longint'(1) <<< (W - 1);
    if (sv) begin
      e.res = av - bv;
      e.co  = (av >= bv);
      sr    = sa - sb;
    end else begin
      t     = {1'b0, av} + {1'b0, bv};
      e.res = t[W-1:0];
      e.co  = t[W];
      sr    = sa + sb;
    end
    e.ov = (sr > lim - 1) || (sr < -lim);
    return e;
  endfunction

  // Presents one request, returns just after the accepting edge.
  task automatic drive_start(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv,
                             input bit push, input bit hold);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    bus.sub   = sv;
    if (push) sbq.push_back(model(av, bv, sv));
    @(posedge clk);
    #1;
    if (!hold) bus.start = 1'b0;
  endtask

  // Counts cycles after the accepting edge until done, bounded.
  task automatic wait_done(output int cyc, output bit seen);
    cyc  = 0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cyc++;
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    tests++; if (bus.ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", bus.ready); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", bus.done); end
    tests++; if (bus.result !== 16'h0000) begin fails++; $display("FAIL reset_result got %h want 0000", bus.result); end
    tests++; if (bus.cout !== 1'b0) begin fails++; $display("FAIL reset_cout got %b want 0", bus.cout); end
    tests++; if (bus.overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow got %b want 0", bus.overflow); end
  endtask

  task automatic test_arith();
    logic [W-1:0] va[11];
    logic [W-1:0] vb[11];
    logic         vs[11];
    int           cyc;
    bit           seen;
    exp_t         e;
    va[0] = 16'h1234; vb[0] = 16'h4321; vs[0] = 1'b0;
    va[1] = 16'hFFFF; vb[1] = 16'h0001; vs[1] = 1'b0;
    va[2] = 16'h7FFF; vb[2] = 16'h0001; vs[2] = 1'b0;
    va[3] = 16'h0005; vb[3] = 16'h0007; vs[3] = 1'b1;
    va[4] = 16'h8000; vb[4] = 16'h0001; vs[4] = 1'b1;
    va[5] = 16'h0000; vb[5] = 16'h0000; vs[5] = 1'b1;
    for (int i = 6; i < 11; i++) begin
      va[i] = W'($urandom);
      vb[i] = W'($urandom);
      vs[i] = 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < 11; i++) begin
      drive_start(va[i], vb[i], vs[i], 1'b1, 1'b0);
      @(negedge clk);
      tests++;
      if (bus.busy !== 1'b1 || bus.ready !== 1'b0) begin
        fails++; $display("FAIL arith_busy[%0d] got busy=%b ready=%b want busy=1 ready=0", i, bus.busy, bus.ready);
      end
      wait_done(cyc, seen);
      cyc++;
      tests++;
      if (!seen) begin
        fails++; $display("FAIL arith_timeout[%0d] no done within bound", i);
      end else begin
        e = sbq.pop_front();
        tests++; if (cyc != N + 1) begin fails++; $display("FAIL arith_latency[%0d] got %0d want %0d", i, cyc, N + 1); end
        tests++; if (bus.result !== e.res) begin fails++; $display("FAIL arith_result[%0d] got %h want %h", i, bus.result, e.res); end
        tests++; if (bus.cout !== e.co) begin fails++; $display("FAIL arith_cout[%0d] got %b want %b", i, bus.cout, e.co); end
        tests++; if (bus.overflow !== e.ov) begin fails++; $display("FAIL arith_overflow[%0d] got %b want %b", i, bus.overflow, e.ov); end
        @(negedge clk);
        tests++;
        if (bus.done !== 1'b0 || bus.ready !== 1'b1 || bus.result !== e.res) begin
          fails++; $display("FAIL arith_after_done[%0d] got done=%b ready=%b result=%h want 0 1 %h", i, bus.done, bus.ready, bus.result, e.res);
        end
      end
    end
  endtask

  task automatic test_ignore_during_run();
    bit   seen;
    int   extra;
    exp_t e;
    drive_start(16'h1234, 16'h4321, 1'b0, 1'b1, 1'b0);
    seen = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (bus.done) begin seen = 1'b1; break; end
      if (c == 2) begin bus.start = 1'b1; bus.a = 16'hFFFF; bus.b = 16'hFFFF; bus.sub = 1'b1; end
      if (c == 4) bus.start = 1'b0;
    end
    tests++;
    if (!seen) begin
      fails++; $display("FAIL ignore_timeout no done within bound");
    end else begin
      e = sbq.pop_front();
      tests++; if (bus.result !== e.res) begin fails++; $display("FAIL ignore_result got %h want %h", bus.result, e.res); end
      tests++; if (bus.cout !== e.co) begin fails++; $display("FAIL ignore_cout got %b want %b", bus.cout, e.co); end
    end
    extra = 0;
    for (int c = 0; c < 2 * N; c++) begin
      @(negedge clk);
      if (bus.done || bus.busy) extra++;
    end
    tests++; if (extra != 0) begin fails++; $display("FAIL ignore_no_second_op got %0d active cycles want 0", extra); end
  endtask

  task automatic test_back_to_back();
    int   dones, released, c, first_c;
    exp_t e;
    sbq.push_back(model(16'h0F0F, 16'h0101, 1'b0));
    sbq.push_back(model(16'h1000, 16'h2001, 1'b1));
    drive_start(16'h0F0F, 16'h0101, 1'b0, 1'b0, 1'b1);
    bus.a   = 16'h1000;
    bus.b   = 16'h2001;
    bus.sub = 1'b1;
    dones = 0; released = 0; c = 0; first_c = 0;
    for (int i = 0; i < 40 && dones < 2; i++) begin
      @(negedge clk);
      c++;
      if (bus.done) begin
        dones++;
        e = sbq.pop_front();
        tests++; if (bus.result !== e.res) begin fails++; $display("FAIL b2b_result[%0d] got %h want %h", dones, bus.result, e.res); end
        tests++; if (bus.overflow !== e.ov) begin fails++; $display("FAIL b2b_overflow[%0d] got %b want %b", dones, bus.overflow, e.ov); end
        if (dones == 1) first_c = c;
        else begin
          tests++; if (c - first_c != N + 2) begin fails++; $display("FAIL b2b_spacing got %0d want %0d", c - first_c, N + 2); end
        end
      end else if (bus.ready && dones == 1 && released == 0) begin
        @(posedge clk);
        #1 bus.start = 1'b0;
        released = 1;
      end
    end
    bus.start = 1'b0;
    tests++; if (dones != 2) begin fails++; $display("FAIL b2b_count got %0d done pulses want 2", dones); end
  endtask

  task automatic test_reset_mid_run();
    int   bad, cyc;
    bit   seen;
    exp_t e;
    drive_start(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 16'h0000 ||
        bus.cout !== 1'b0 || bus.overflow !== 1'b0) begin
      fails++; $display("FAIL midrun_reset_state got ready=%b busy=%b done=%b result=%h cout=%b ovf=%b want 1 0 0 0000 0 0",
                        bus.ready, bus.busy, bus.done, bus.result, bus.cout, bus.overflow);
    end
    bad = 0;
    for (int c = 0; c < 2 * N; c++) begin
      @(negedge clk);
      if (bus.done) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL midrun_no_done got %0d pulses want 0", bad); end
    drive_start(16'h8001, 16'h8001, 1'b0, 1'b1, 1'b0);
    wait_done(cyc, seen);
    tests++;
    if (!seen) begin
      fails++; $display("FAIL midrun_recover_timeout no done within bound");
    end else begin
      e = sbq.pop_front();
      tests++; if (bus.result !== e.res) begin fails++; $display("FAIL midrun_recover_result got %h want %h", bus.result, e.res); end
      tests++; if (bus.cout !== e.co || bus.overflow !== e.ov) begin
        fails++; $display("FAIL midrun_recover_flags got cout=%b ovf=%b want %b %b", bus.cout, bus.overflow, e.co, e.ov);
      end
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_ignore_during_run();
    test_back_to_back();
    test_reset_mid_run();
    tests++;
    if (sbq.size() != 0) begin fails++; $display("FAIL scoreboard_drain got %0d left want 0", sbq.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
